datapath: RTL and testbench

- 32-bit single-bus processor datapath slice: bus multiplexer; registers R1, R2, R3, PC, IR, MDR, Y and Zlow; AND-capable ALU.
- Driven cycle-by-cycle by an external control unit or bench through discrete out/in/op strobes.
- Used to run register-load and ALU micro-sequences, e.g. "and R1, R2, R3".

---
 rtl/datapath_pkg.sv | 32 +++
 rtl/datapath_register32.sv | 30 +++
 rtl/datapath.sv | 94 +++++++++
 tb/tb_datapath.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath: data width and bus-source
// priority encoding.
package datapath_pkg;

   localparam int DP_WIDTH = 32;

   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_R3   = 3'd1,
      SRC_R2   = 3'd2,
      SRC_PC   = 3'd3,
      SRC_MDR  = 3'd4,
      SRC_ZLOW = 3'd5
   } bus_src_e;

   // Fixed priority Zlow > MDR > PC > R2 > R3 when several out strobes collide.
   function automatic bus_src_e bus_select(
      input logic zlow_out,
      input logic mdr_out,
      input logic pc_out,
      input logic r2_out,
      input logic r3_out
   );
      if (zlow_out)     return SRC_ZLOW;
      else if (mdr_out) return SRC_MDR;
      else if (pc_out)  return SRC_PC;
      else if (r2_out)  return SRC_R2;
      else if (r3_out)  return SRC_R3;
      else              return SRC_NONE;
   endfunction

endpackage

// File: rtl/datapath_register32.sv
// Generic WIDTH-bit register with load enable and asynchronous active-low clear.
module register32 #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      // NOTE: every path assigns data_d, so no latch can be inferred.
      data_d = data_q;
      if (en) data_d = d;
   end

   // NOTE: clear is in the sensitivity list so it acts without waiting for a clock edge.
   always_ff @(posedge clock or negedge clear) begin
      // NOTE: non-blocking assignment keeps all registers sampling pre-edge values.
      if (!clear) data_q <= '0;
      else        data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/datapath.sv
// 32-bit single-bus datapath slice: bus mux, R1-R3, PC, IR, MDR, Y, Zlow and an AND ALU.
module datapath
   import datapath_pkg::*;
#(
   parameter int WIDTH = DP_WIDTH
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             PCout,
   input  logic             Zlowout,
   input  logic             MDRout,
   input  logic             R2out,
   input  logic             R3out,
   input  logic             MDRin,
   input  logic             Yin,
   input  logic             IRin,
   input  logic             R1in,
   input  logic             R2in,
   input  logic             R3in,
   input  logic             Read,
   input  logic             AND,
   input  logic [WIDTH-1:0] Mdatain,
   output logic [WIDTH-1:0] BusMuxOut,
   output logic [WIDTH-1:0] R1_q,
   output logic [WIDTH-1:0] IR_q
);

   bus_src_e         bus_src;
   logic [WIDTH-1:0] bus;
   logic [WIDTH-1:0] r2_q;
   logic [WIDTH-1:0] r3_q;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] mdr_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] zlow_q;
   logic [WIDTH-1:0] mdr_d;
   logic [WIDTH-1:0] zlow_d;

   assign bus_src = bus_select(Zlowout, MDRout, PCout, R2out, R3out);

   always_comb begin
      bus = '0;
      case (bus_src)
         SRC_ZLOW: bus = zlow_q;
         SRC_MDR:  bus = mdr_q;
         SRC_PC:   bus = pc_q;
         SRC_R2:   bus = r2_q;
         SRC_R3:   bus = r3_q;
         default:  bus = '0;
      endcase
   end

   assign BusMuxOut = bus;

   always_comb begin
      mdr_d  = Read ? Mdatain : bus;
      zlow_d = y_q & bus;
   end

   register32 #(.WIDTH(WIDTH)) u_r1 (
      .clock(clock), .clear(clear), .en(R1in), .d(bus), .q(R1_q)
   );

   register32 #(.WIDTH(WIDTH)) u_r2 (
      .clock(clock), .clear(clear), .en(R2in), .d(bus), .q(r2_q)
   );

   register32 #(.WIDTH(WIDTH)) u_r3 (
      .clock(clock), .clear(clear), .en(R3in), .d(bus), .q(r3_q)
   );

   // PC has no load or increment path here; it only ever holds its reset value.
   register32 #(.WIDTH(WIDTH)) u_pc (
      .clock(clock), .clear(clear), .en(1'b0), .d(bus), .q(pc_q)
   );

   register32 #(.WIDTH(WIDTH)) u_ir (
      .clock(clock), .clear(clear), .en(IRin), .d(bus), .q(IR_q)
   );

   register32 #(.WIDTH(WIDTH)) u_mdr (
      .clock(clock), .clear(clear), .en(MDRin), .d(mdr_d), .q(mdr_q)
   );

   register32 #(.WIDTH(WIDTH)) u_y (
      .clock(clock), .clear(clear), .en(Yin), .d(bus), .q(y_q)
   );

   // The AND strobe doubles as Zlow's load enable.
   register32 #(.WIDTH(WIDTH)) u_zlow (
      .clock(clock), .clear(clear), .en(AND), .d(zlow_d), .q(zlow_q)
   );

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed micro-sequences plus random strobes
// checked against a register-file model.
module tb_datapath;

   typedef struct packed {
      logic pc_out;
      logic zlow_out;
      logic mdr_out;
      logic r2_out;
      logic r3_out;
      logic mdr_in;
      logic y_in;
      logic ir_in;
      logic r1_in;
      logic r2_in;
      logic r3_in;
      logic read;
      logic and_op;
   } strobes_t;

   localparam int I_R1 = 0, I_R2 = 1, I_R3 = 2, I_PC = 3,
                  I_IR = 4, I_MDR = 5, I_Y = 6, I_Z = 7;

   logic        clock;
   logic        clear;
   strobes_t    cur_s;
   logic [31:0] cur_din;
   logic [31:0] bus_mux_out, r1_q, ir_q;

   logic [31:0] m [8];
   int tests_run;
   int failures;

   datapath dut (
      .clock(clock), .clear(clear),
      .PCout(cur_s.pc_out), .Zlowout(cur_s.zlow_out), .MDRout(cur_s.mdr_out),
      .R2out(cur_s.r2_out), .R3out(cur_s.r3_out),
      .MDRin(cur_s.mdr_in), .Yin(cur_s.y_in), .IRin(cur_s.ir_in),
      .R1in(cur_s.r1_in), .R2in(cur_s.r2_in), .R3in(cur_s.r3_in),
      .Read(cur_s.read), .AND(cur_s.and_op), .Mdatain(cur_din),
      .BusMuxOut(bus_mux_out), .R1_q(r1_q), .IR_q(ir_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] model_bus(input strobes_t s);
      logic       en [5];
      int         idx [5];
      en  = '{s.zlow_out, s.mdr_out, s.pc_out, s.r2_out, s.r3_out};
      idx = '{I_Z, I_MDR, I_PC, I_R2, I_R3};
      for (int k = 0; k < 5; k++)
         if (en[k]) return m[idx[k]];
      return 32'h0;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 8; k++) m[k] = 32'h0;
   endtask

   task automatic set_in(input strobes_t s, input logic [31:0] din);
      cur_s   = s;
      cur_din = din;
      #1;
   endtask

   // Advance one rising edge, updating the model from the strobes in effect.
   task automatic tick();
      logic [31:0] nm [8];
      logic [31:0] b;
      b  = model_bus(cur_s);
      nm = m;
      if (cur_s.r1_in)  nm[I_R1]  = b;
      if (cur_s.r2_in)  nm[I_R2]  = b;
      if (cur_s.r3_in)  nm[I_R3]  = b;
      if (cur_s.ir_in)  nm[I_IR]  = b;
      if (cur_s.y_in)   nm[I_Y]   = b;
      if (cur_s.mdr_in) nm[I_MDR] = cur_s.read ? cur_din : b;
      if (cur_s.and_op) nm[I_Z]   = m[I_Y] & b;
      @(posedge clock);
      if (clear) m = nm;
      else       model_clear();
      #1;
      cur_s = '0;
   endtask

   task automatic test_reset();
      strobes_t s;
      clear = 1'b0;
      model_clear();
      s = '0;
      s.pc_out = 1'b1; s.r1_in = 1'b1; s.ir_in = 1'b1; s.mdr_in = 1'b1; s.read = 1'b1;
      set_in(s, 32'hDEAD_BEEF);
      tick();
      set_in(s, 32'hDEAD_BEEF);
      tests_run++;
      if (bus_mux_out !== 32'h0) begin
         failures++; $display("FAIL reset_bus got=%h exp=%h", bus_mux_out, 32'h0);
      end
      tests_run++;
      if (r1_q !== 32'h0 || ir_q !== 32'h0) begin
         failures++; $display("FAIL reset_regs r1=%h ir=%h exp=0", r1_q, ir_q);
      end
      tick();
      clear = 1'b1;
      set_in('0, 32'h0);
      tick();
      tests_run++;
      if (r1_q !== 32'h0 || ir_q !== 32'h0 || bus_mux_out !== 32'h0) begin
         failures++; $display("FAIL release_hold r1=%h ir=%h bus=%h exp=0", r1_q, ir_q, bus_mux_out);
      end
   endtask

   task automatic load_via_mdr(input logic [31:0] val, input int dst);
      strobes_t s;
      s = '0; s.mdr_in = 1'b1; s.read = 1'b1;
      set_in(s, val);
      tick();
      s = '0; s.mdr_out = 1'b1;
      s.r1_in = (dst == I_R1); s.r2_in = (dst == I_R2);
      s.r3_in = (dst == I_R3); s.ir_in = (dst == I_IR);
      set_in(s, 32'h0);
      tests_run++;
      if (bus_mux_out !== val) begin
         failures++; $display("FAIL mdr_bus dst=%0d got=%h exp=%h", dst, bus_mux_out, val);
      end
      tick();
   endtask

   task automatic test_register_load();
      load_via_mdr(32'h12, I_R2);
      load_via_mdr(32'h14, I_R3);
      load_via_mdr(32'h18, I_R1);
      tests_run++;
      if (r1_q !== 32'h18) begin
         failures++; $display("FAIL r1_load got=%h exp=%h", r1_q, 32'h18);
      end
   endtask

   task automatic test_ir_fetch();
      load_via_mdr(32'h3, I_IR);
      tests_run++;
      if (ir_q !== 32'h0000_0003) begin
         failures++; $display("FAIL ir_fetch got=%h exp=%h", ir_q, 32'h3);
      end
   endtask

   task automatic test_and_sequence();
      strobes_t s;
      s = '0; s.r2_out = 1'b1; s.y_in = 1'b1;
      set_in(s, 32'h0);
      tick();
      s = '0; s.r3_out = 1'b1; s.and_op = 1'b1;
      set_in(s, 32'h0);
      tick();
      s = '0; s.zlow_out = 1'b1; s.r1_in = 1'b1;
      set_in(s, 32'h0);
      tests_run++;
      if (bus_mux_out !== 32'h10) begin
         failures++; $display("FAIL zlow_bus got=%h exp=%h", bus_mux_out, 32'h10);
      end
      tick();
      tests_run++;
      if (r1_q !== 32'h10) begin
         failures++; $display("FAIL and_result_r1 got=%h exp=%h", r1_q, 32'h10);
      end
   endtask

   task automatic test_bus_priority();
      strobes_t s;
      s = '0; s.mdr_in = 1'b1; s.read = 1'b1;
      set_in(s, 32'hA);
      tick();
      s = '0; s.mdr_out = 1'b1; s.r2_out = 1'b1;
      set_in(s, 32'h0);
      tests_run++;
      if (bus_mux_out !== 32'hA) begin
         failures++; $display("FAIL prio_mdr_r2 got=%h exp=%h", bus_mux_out, 32'hA);
      end
      s = '0; s.zlow_out = 1'b1; s.mdr_out = 1'b1; s.r3_out = 1'b1;
      set_in(s, 32'h0);
      tests_run++;
      if (bus_mux_out !== 32'h10) begin
         failures++; $display("FAIL prio_zlow got=%h exp=%h", bus_mux_out, 32'h10);
      end
      s = '0; s.pc_out = 1'b1; s.r2_out = 1'b1;
      set_in(s, 32'h0);
      tests_run++;
      if (bus_mux_out !== 32'h0) begin
         failures++; $display("FAIL prio_pc got=%h exp=%h", bus_mux_out, 32'h0);
      end
      s = '0; s.r2_out = 1'b1; s.r3_out = 1'b1;
      set_in(s, 32'h0);
      tests_run++;
      if (bus_mux_out !== 32'h12) begin
         failures++; $display("FAIL prio_r2_r3 got=%h exp=%h", bus_mux_out, 32'h12);
      end
      set_in('0, 32'h0);
      tests_run++;
      if (bus_mux_out !== 32'h0) begin
         failures++; $display("FAIL no_source got=%h exp=%h", bus_mux_out, 32'h0);
      end
   endtask

   task automatic test_async_reset();
      strobes_t s;
      s = '0; s.r2_out = 1'b1; s.y_in = 1'b1;
      set_in(s, 32'h0);
      tick();
      s = '0; s.zlow_out = 1'b1;
      set_in(s, 32'h0);
      clear = 1'b0;
      model_clear();
      #1;
      tests_run++;
      if (r1_q !== 32'h0 || bus_mux_out !== 32'h0) begin
         failures++; $display("FAIL async_clear r1=%h zlow_bus=%h exp=0", r1_q, bus_mux_out);
      end
      #2;
      clear = 1'b1;
      // All-ones on the bus exposes any surviving bit of Y through the AND.
      s = '0; s.mdr_in = 1'b1; s.read = 1'b1;
      set_in(s, 32'hFFFF_FFFF);
      tick();
      s = '0; s.mdr_out = 1'b1; s.and_op = 1'b1;
      set_in(s, 32'h0);
      tick();
      s = '0; s.zlow_out = 1'b1;
      set_in(s, 32'h0);
      tests_run++;
      if (bus_mux_out !== 32'h0) begin
         failures++; $display("FAIL and_after_clear got=%h exp=%h", bus_mux_out, 32'h0);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_bus;
      for (int n = 0; n < 300; n++) begin
         set_in(strobes_t'(13'($urandom)), $urandom);
         exp_bus = model_bus(cur_s);
         tests_run++;
         if (bus_mux_out !== exp_bus) begin
            failures++; $display("FAIL rand_bus n=%0d got=%h exp=%h", n, bus_mux_out, exp_bus);
         end
         tick();
         tests_run++;
         if (r1_q !== m[I_R1] || ir_q !== m[I_IR]) begin
            failures++;
            $display("FAIL rand_regs n=%0d r1=%h exp=%h ir=%h exp=%h", n, r1_q, m[I_R1], ir_q, m[I_IR]);
         end
      end
   endtask

   initial begin
      tests_run = 0;
      failures  = 0;
      cur_s     = '0;
      cur_din   = 32'h0;
      clear     = 1'b0;
      model_clear();
      @(posedge clock);
      #1;
      test_reset();
      test_register_load();
      test_ir_fetch();
      test_and_sequence();
      test_bus_priority();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
